booth_multiplier: RTL

//   Sequential signed radix-2 Booth multiplier: the multiply counterpart of the
//   non-restoring divider in the same arithmetic library. Takes two WIDTH-bit
//   two's-complement operands on a start pulse, iterates one Booth step per clock,

---
 rtl/booth_multiplier.sv | 119 +++++++++++
 1 files changed

// File: rtl/booth_multiplier.sv
// -----------------------------------------------------------------------------
// booth_multiplier
//   Sequential signed radix-2 Booth multiplier. A start pulse in IDLE latches
//   two WIDTH-bit two's-complement operands; one Booth step runs per clock for
//   WIDTH clocks. The 2*WIDTH-bit signed product is then presented together
//   with a one-cycle done pulse.
//
// Parameters
//   WIDTH    operand width in bits (>= 2); the product is 2*WIDTH bits
//
// Ports
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous reset, active-high
//   start    in   1          request; sampled only while idle
//   M        in   WIDTH      multiplicand, signed, latched on accepted start
//   Q        in   WIDTH      multiplier, signed, latched on accepted start
//   busy     out  1          high while iterating
//   done     out  1          one-cycle pulse, product valid
//   product  out  2*WIDTH    signed M*Q, held until the next completion
// -----------------------------------------------------------------------------
module booth_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   q_reg;
    // One guard bit above WIDTH so that subtracting the most negative
    // multiplicand cannot overflow the partial accumulator.
    logic [WIDTH:0]     a_reg;
    logic               q_m1;
    logic [CW-1:0]      count;

    // Combinational Booth step on the current registers.
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     a_sum;
    logic [WIDTH:0]     a_next;
    logic [WIDTH-1:0]   q_next;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        m_ext = {m_reg[WIDTH-1], m_reg};
        a_sum = a_reg;
        unique case ({q_reg[0], q_m1})
            2'b01:   a_sum = a_reg + m_ext;
            2'b10:   a_sum = a_reg - m_ext;
            default: a_sum = a_reg;
        endcase
        // Arithmetic shift right of {A, Q, q_m1}; the bit that falls out of
        // A moves into the top of Q, and A's sign bit is replicated.
        a_next = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_next = {a_sum[0], q_reg[WIDTH-1:1]};
    end

    // NOTE: state registers are written with non-blocking assignments so all
    // of them update from the same pre-edge values, independent of statement
    // order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m_reg   <= '0;
            q_reg   <= '0;
            a_reg   <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= M;
                        q_reg <= Q;
                        a_reg <= '0;
                        q_m1  <= 1'b0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_m1  <= q_reg[0];
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        // The guard bit of A is dropped: the true product
                        // always fits in 2*WIDTH signed bits.
                        product <= {a_next[WIDTH-1:0], q_next};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
